// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU front end: next-PC select codes,
// sequencer states and the instruction word size.
package cpu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    PCSRC_PC4 = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_REG = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit to PC-sequencer bus: next-PC request inputs and the
// program-counter status returned to the control unit.
interface pc_sequencer_if #(
  parameter int CNT_W = 16
);

  logic             PCWre;
  logic [1:0]       PCSrc;
  logic [31:0]      Imm;
  logic [31:0]      RegData;
  logic [31:0]      JumpTarget;
  logic             Halt;
  logic [31:0]      PC;
  logic [31:0]      PC4;
  logic [1:0]       State;
  logic [31:0]      FaultAddr;
  logic [CNT_W-1:0] RetireCnt;

  modport master (
    output PCWre, PCSrc, Imm, RegData, JumpTarget, Halt,
    input  PC, PC4, State, FaultAddr, RetireCnt
  );

  modport slave (
    input  PCWre, PCSrc, Imm, RegData, JumpTarget, Halt,
    output PC, PC4, State, FaultAddr, RetireCnt
  );

endinterface

// File: rtl/pc_sequencer_npc_select.sv
// Combinational next-PC mux plus the misalignment and jump-region fault
// check; has no state so it can be reused anywhere an NPC is needed.
module npc_select
  import cpu_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [31:0] reg_data,
  input  logic [31:0] jump_target,
  output logic [31:0] npc,
  output logic        fault
);

  logic [31:0] br_target;
  logic        region_bad;

  // PC4 is always word aligned and the offset is shifted by two, so the
  // branch target can never be misaligned.
  assign br_target = pc4 + (imm << 2);

  always_comb begin
    npc = pc4;
    case (pcsrc_e'(pc_src))
      PCSRC_PC4: npc = pc4;
      PCSRC_BR:  npc = br_target;
      PCSRC_REG: npc = reg_data;
      PCSRC_J:   npc = jump_target;
      default:   npc = pc4;
    endcase
  end

  assign region_bad = (pcsrc_e'(pc_src) == PCSRC_J) &&
                      (jump_target[31:28] != pc4[31:28]);
  assign fault      = (npc[1:0] != 2'b00) || region_bad;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer with sticky HALTED/FAULT
// states and a retired-update counter.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  pc_sequencer_if.slave      bus
);

  logic [31:0]      pc_q, pc_d;
  state_e           state_q, state_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic [31:0]      pc4;
  logic [31:0]      npc;
  logic             npc_fault;

  assign pc4 = pc_q + 32'(WORD_BYTES);

  npc_select u_npc_select (
    .pc4         (pc4),
    .pc_src      (bus.PCSrc),
    .imm         (bus.Imm),
    .reg_data    (bus.RegData),
    .jump_target (bus.JumpTarget),
    .npc         (npc),
    .fault       (npc_fault)
  );

  // Halt wins over a same-cycle PC write; the illegal state encoding
  // recovers into FAULT, reporting the PC it was stuck at.
  always_comb begin
    pc_d         = pc_q;
    state_d      = state_q;
    fault_addr_d = fault_addr_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.Halt) begin
          state_d = ST_HALT;
        end else if (bus.PCWre) begin
          if (npc_fault) begin
            fault_addr_d = npc;
            state_d      = ST_FAULT;
          end else begin
            pc_d         = npc;
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HALT, ST_FAULT: begin
      end
      default: begin
        state_d      = ST_FAULT;
        fault_addr_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc_q         <= RESET_PC;
      state_q      <= ST_RUN;
      fault_addr_q <= 32'h0000_0000;
      retire_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      fault_addr_q <= fault_addr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.PC4       = pc4;
  assign bus.State     = state_q;
  assign bus.FaultAddr = fault_addr_q;
  assign bus.RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, counter-wrap
// sequence and a randomized run against a behavioural model.
module tb_pc_sequencer;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic CLK;
  logic Reset;
  int   checks;
  int   errors;

  pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic             rst_n;
    logic             halt;
    logic             wre;
    logic [1:0]       src;
    logic [31:0]      imm;
    logic [31:0]      rd;
    logic [31:0]      jt;
    logic [31:0]      exp_pc;
    logic [1:0]       exp_st;
    logic [31:0]      exp_fa;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic halt, input logic wre,
                              input logic [1:0] src, input logic [31:0] imm,
                              input logic [31:0] rd, input logic [31:0] jt,
                              input logic [31:0] e_pc, input logic [1:0] e_st,
                              input logic [31:0] e_fa, input int e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.halt = halt; v.wre = wre; v.src = src;
    v.imm = imm; v.rd = rd; v.jt = jt;
    v.exp_pc = e_pc; v.exp_st = e_st; v.exp_fa = e_fa;
    v.exp_cnt = CNT_W'(e_cnt);
    return v;
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic halt, input logic wre,
                               input logic [1:0] src, input logic [31:0] imm,
                               input logic [31:0] rd, input logic [31:0] jt);
    Reset          = rst_n;
    bus.Halt       = halt;
    bus.PCWre      = wre;
    bus.PCSrc      = src;
    bus.Imm        = imm;
    bus.RegData    = rd;
    bus.JumpTarget = jt;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] e_pc, input logic [1:0] e_st,
                             input logic [31:0] e_fa, input logic [CNT_W-1:0] e_cnt);
    checkVal({tag, ".PC"}, bus.PC, e_pc);
    checkVal({tag, ".PC4"}, bus.PC4, e_pc + 32'd4);
    checkVal({tag, ".State"}, {30'd0, bus.State}, {30'd0, e_st});
    checkVal({tag, ".FaultAddr"}, bus.FaultAddr, e_fa);
    checkVal({tag, ".RetireCnt"}, 32'(bus.RetireCnt), 32'(e_cnt));
  endtask

  // Behavioural reference: architectural state advanced by the stated rules.
  int unsigned m_pc, m_fa, m_cnt, m_st;

  task automatic modelStep(input logic rst_n, input logic halt, input logic wre,
                           input logic [1:0] src, input int unsigned imm,
                           input int unsigned rd, input int unsigned jt);
    int unsigned npc;
    bit          bad;
    if (!rst_n) begin
      m_pc = RESET_PC; m_st = 0; m_fa = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (halt) begin
        m_st = 1;
      end else if (wre) begin
        case (src)
          2'd0:    npc = m_pc + 4;
          2'd1:    npc = m_pc + 4 + imm * 4;
          2'd2:    npc = rd;
          default: npc = jt;
        endcase
        bad = (npc % 4 != 0) || (src == 2'd3 && (jt >> 28) != ((m_pc + 4) >> 28));
        if (bad) begin
          m_fa = npc; m_st = 2;
        end else begin
          m_pc = npc; m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end
  endtask

  initial begin
    logic        r_rst, r_halt, r_wre;
    logic [1:0]  r_src;
    int unsigned r_imm, r_rd, r_jt;

    checks = 0;
    errors = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);

    // Directed table: reset, sequential, branch/wrap, jump region, jr misalign, halt.
    vecs.push_back(mk(0,0,1,2'd3,32'h0,32'h0,32'hFFFF_0000, 32'h0,2'd0,32'h0,0));
    vecs.push_back(mk(0,0,1,2'd3,32'h0,32'h0,32'hFFFF_0000, 32'h0,2'd0,32'h0,0));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0, 32'h4,2'd0,32'h0,1));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0, 32'h8,2'd0,32'h0,2));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0, 32'hC,2'd0,32'h0,3));
    vecs.push_back(mk(1,0,0,2'd2,32'h1234,32'h3,32'h7,   32'hC,2'd0,32'h0,3));
    vecs.push_back(mk(1,0,1,2'd2,32'h0,32'h10,32'h0,     32'h10,2'd0,32'h0,4));
    vecs.push_back(mk(1,0,1,2'd1,32'hFFFF_FFFC,32'h0,32'h0, 32'h4,2'd0,32'h0,5));
    vecs.push_back(mk(1,0,1,2'd2,32'h0,32'hFFFF_FFFC,32'h0, 32'hFFFF_FFFC,2'd0,32'h0,6));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0,      32'h0,2'd0,32'h0,7));
    vecs.push_back(mk(1,0,1,2'd2,32'h0,32'h1000_0000,32'h0, 32'h1000_0000,2'd0,32'h0,8));
    vecs.push_back(mk(1,0,1,2'd3,32'h0,32'h0,32'h1000_0100, 32'h1000_0100,2'd0,32'h0,9));
    vecs.push_back(mk(1,0,1,2'd3,32'h0,32'h0,32'h2000_0100, 32'h1000_0100,2'd2,32'h2000_0100,9));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0,      32'h1000_0100,2'd2,32'h2000_0100,9));
    vecs.push_back(mk(1,1,0,2'd0,32'h0,32'h0,32'h0,      32'h1000_0100,2'd2,32'h2000_0100,9));
    vecs.push_back(mk(0,1,1,2'd0,32'h0,32'h0,32'h0,      32'h0,2'd0,32'h0,0));
    vecs.push_back(mk(1,0,1,2'd2,32'h0,32'h42,32'h0,     32'h0,2'd2,32'h42,0));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0,      32'h0,2'd2,32'h42,0));
    vecs.push_back(mk(0,0,0,2'd0,32'h0,32'h0,32'h0,      32'h0,2'd0,32'h0,0));
    vecs.push_back(mk(1,0,1,2'd2,32'h0,32'h1C,32'h0,     32'h1C,2'd0,32'h0,1));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0,      32'h20,2'd0,32'h0,2));
    vecs.push_back(mk(1,1,1,2'd0,32'h0,32'h0,32'h0,      32'h20,2'd1,32'h0,2));
    vecs.push_back(mk(1,0,1,2'd0,32'h0,32'h0,32'h0,      32'h20,2'd1,32'h0,2));
    vecs.push_back(mk(1,0,1,2'd2,32'h0,32'h44,32'h0,     32'h20,2'd1,32'h0,2));
    vecs.push_back(mk(0,0,0,2'd0,32'h0,32'h0,32'h0,      32'h0,2'd0,32'h0,0));
    vecs.push_back(mk(1,0,1,2'd3,32'h0,32'h0,32'h0000_0102, 32'h0,2'd2,32'h102,0));
    vecs.push_back(mk(0,0,0,2'd0,32'h0,32'h0,32'h0,      32'h0,2'd0,32'h0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].halt, vecs[i].wre, vecs[i].src,
                    vecs[i].imm, vecs[i].rd, vecs[i].jt);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_st,
                  vecs[i].exp_fa, vecs[i].exp_cnt);
    end

    // Counter wrap: 16 updates bring a 4-bit count back to 0, the 17th gives 1.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
      checkOutput($sformatf("wrap%0d", i), 32'((i + 1) * 4), 2'd0, 32'h0,
                  CNT_W'((i + 1) % 16));
    end

    m_pc = 0; m_st = 0; m_fa = 0; m_cnt = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      r_rst  = ($urandom_range(0, 31) != 0);
      r_halt = ($urandom_range(0, 39) == 0);
      r_wre  = $urandom_range(0, 1) == 1;
      r_src  = 2'($urandom_range(0, 3));
      r_imm  = 32'($urandom_range(0, 64)) - 32'd32;
      r_rd   = $urandom();
      if ($urandom_range(0, 7) != 0) r_rd = r_rd & 32'hFFFF_FFFC;
      r_jt   = $urandom();
      if ($urandom_range(0, 7) != 0)
        r_jt = ((m_pc + 4) & 32'hF000_0000) | (r_jt & 32'h0FFF_FFFC);
      modelStep(r_rst, r_halt, r_wre, r_src, r_imm, r_rd, r_jt);
      applyStimulus(r_rst, r_halt, r_wre, r_src, r_imm, r_rd, r_jt);
      checkOutput($sformatf("rnd%0d", i), m_pc, 2'(m_st), m_fa, CNT_W'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC sequencer for the multicycle CPU.
- Consumer end of the jump-address interface: takes the already-formed 32-bit jump target ({PC4[31:28], index, 00}), branch offset and register target.
- Commits the selected address to PC when the control unit asserts PCWre.
- Checks alignment and jump-region consistency; keeps a retired-instruction count; has sticky HALTED/FAULT states.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
CNT_W, 16, width of retired-update counter

Ports:
CLK  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-low reset; sampled on rising CLK
PCWre  input  1  PC write enable from control unit (one pulse per instruction)
PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 register, 11 jump
Imm  input  32  sign-extended branch immediate (word offset)
RegData  input  32  register-target address (jr)
JumpTarget  input  32  formed jump address for PCSrc=11
Halt  input  1  halt request from control unit
PC  output  32  current program counter
PC4  output  32  PC + 4, combinational, wraps mod 2^32
State  output  2  00 RUN, 01 HALTED, 10 FAULT
FaultAddr  output  32  offending next-PC value latched on fault
RetireCnt  output  CNT_W  count of committed PC updates

Behaviour:
- Reset (Reset==0 at rising edge): PC=RESET_PC, State=RUN, FaultAddr=0, RetireCnt=0. Reset overrides every other input, including mid-fault and mid-halt.
- PC4 = PC + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), purely combinational.
- Candidate next address NPC, combinational:
  - 00: PC4
  - 01: PC4 + (Imm << 2), 32-bit wrap, low 2 bits of the result are 00
  - 10: RegData
  - 11: JumpTarget
- Fault conditions, evaluated only when PCWre=1 in RUN:
  - a) NPC[1:0] != 00 (misaligned)
  - b) PCSrc==11 and JumpTarget[31:28] != PC4[31:28] (region mismatch)
- RUN, one rising edge:
  - Halt=1: PC unchanged, State->HALTED, no count. Halt has priority over PCWre.
  - Else PCWre=1 with fault: PC unchanged, FaultAddr<=NPC, State->FAULT, no count.
  - Else PCWre=1 without fault: PC<=NPC, RetireCnt<=RetireCnt+1 (wraps at 2^CNT_W).
  - Else PCWre=0: hold everything.
- HALTED and FAULT are sticky until reset.
  - PCWre and Halt are ignored; PC, FaultAddr and RetireCnt hold.
- Latency: an update sampled at edge N is visible on PC after edge N; PC4 follows in the same cycle.
- PCSrc, Imm, RegData and JumpTarget are don't-care when PCWre=0. No X may propagate into state.
- State encoding 11 is unreachable. If entered, the block goes to FAULT on the next edge with FaultAddr=PC.

Decomposition:
- Shared package cpu_pkg:
  - PCSrc encodings: PCSRC_PC4, PCSRC_BR, PCSRC_REG, PCSRC_J
  - State encodings: ST_RUN, ST_HALT, ST_FAULT
  - Constant WORD_BYTES=4
- One natural sub-module, npc_select: combinational NPC mux plus the fault check. It is reusable by the bench as a reference model.
- Register, counter and FSM stay in pc_sequencer.

Test Plan:
1. Reset: hold Reset=0 for 2 cycles with PCWre=1 and PCSrc=11 -> PC=0, State=00, RetireCnt=0. Then release, 3 PCWre pulses with PCSrc=00 -> PC=0x0C, RetireCnt=3.
2. Branch and wrap:
   - PC=0x0000_0010, Imm=0xFFFF_FFFC, PCSrc=01 -> PC=0x0000_0004.
   - PC=0xFFFF_FFFC, PCSrc=00 -> PC=0, PC4=4.
3. Jump region:
   - PC=0x1000_0000, JumpTarget=0x1000_0100, PCSrc=11 -> PC=0x1000_0100.
   - JumpTarget=0x2000_0100 -> State=FAULT, FaultAddr=0x2000_0100, PC unchanged.
4. Misaligned jr: RegData=0x0000_0042, PCSrc=10, PCWre=1 -> FAULT, FaultAddr=0x42. Further PCWre pulses change nothing; Reset=0 restores PC=RESET_PC, State=RUN.
5. Halt priority: Halt=1 and PCWre=1 in the same cycle (PCSrc=00, PC=0x20) -> PC stays 0x20, State=HALTED, RetireCnt unchanged. Later PCWre pulses are ignored.
6. Counter wrap: with CNT_W=4, 16 valid updates -> RetireCnt returns to 0; the 17th update -> 1.
